// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller monitor: opcode and
// funct encodings, ALU control codes, expected-FSM state, retire class and
// error code enums, plus packed views of the observed controller signals.
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct fields
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    // ClsNone doubles as the idle/reset value of retire_cls
    typedef enum logic [2:0] {
        ClsNone  = 3'd0,
        ClsLw    = 3'd1,
        ClsSw    = 3'd2,
        ClsRtype = 3'd3,
        ClsBeq   = 3'd4,
        ClsAddi  = 3'd5,
        ClsJ     = 3'd6
    } cls_e;

    typedef enum logic [2:0] {
        ErrNone   = 3'd0,
        ErrBadop  = 3'd1,
        ErrStrobe = 3'd2,
        ErrAlu    = 3'd3,
        ErrMux    = 3'd4
    } err_e;

    typedef struct packed {
        logic pcen;
        logic memwrite;
        logic irwrite;
        logic regwrite;
    } strobe_t;

    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
    } mux_t;

    // Each instruction class ends in exactly one state, so the class of a
    // retiring instruction follows from the state alone.
    function automatic cls_e retire_class(input state_e s);
        case (s)
            StMemWb:  retire_class = ClsLw;
            StMemWr:  retire_class = ClsSw;
            StAluWb:  retire_class = ClsRtype;
            StBranch: retire_class = ClsBeq;
            StAddiWb: retire_class = ClsAddi;
            StJump:   retire_class = ClsJ;
            default:  retire_class = ClsNone;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_expect.sv
// Combinational expectation table for the controller monitor.
// Ports:
//   state      in   expected FSM state
//   funct      in   instruction funct field (used in EXECUTE)
//   zero       in   ALU zero flag (sets expected pcen in BRANCH)
//   exp_strobe out  expected pcen/memwrite/irwrite/regwrite (always checked)
//   exp_mux    out  expected mux selects
//   mux_mask   out  which mux select bits are checked in this state
//   exp_alu    out  expected alucontrol
//   alu_check  out  alucontrol is checked in this state
//   funct_bad  out  unknown funct in EXECUTE
module mips_ctrl_expect
    import mips_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] funct,
    input  logic       zero,
    output strobe_t    exp_strobe,
    output mux_t       exp_mux,
    output mux_t       mux_mask,
    output logic [3:0] exp_alu,
    output logic       alu_check,
    output logic       funct_bad
);

    always_comb begin
        exp_strobe = '0;
        exp_mux    = '0;
        mux_mask   = '0;
        exp_alu    = ALU_ADD;
        alu_check  = 1'b0;
        funct_bad  = 1'b0;

        case (state)
            StFetch: begin
                exp_strobe.pcen    = 1'b1;
                exp_strobe.irwrite = 1'b1;
                exp_mux.alusrcb    = 2'b01;
                mux_mask.iord      = 1'b1;
                mux_mask.alusrca   = 1'b1;
                mux_mask.alusrcb   = 2'b11;
                mux_mask.pcsrc     = 2'b11;
                alu_check          = 1'b1;
            end
            StDecode: begin
                exp_mux.alusrcb  = 2'b11;
                mux_mask.alusrcb = 2'b11;
                alu_check        = 1'b1;
            end
            StMemAdr, StAddiEx: begin
                exp_mux.alusrca  = 1'b1;
                exp_mux.alusrcb  = 2'b10;
                mux_mask.alusrca = 1'b1;
                mux_mask.alusrcb = 2'b11;
                alu_check        = 1'b1;
            end
            StMemRd: begin
                exp_mux.iord  = 1'b1;
                mux_mask.iord = 1'b1;
            end
            StMemWr: begin
                exp_strobe.memwrite = 1'b1;
                exp_mux.iord        = 1'b1;
                mux_mask.iord       = 1'b1;
            end
            StMemWb: begin
                exp_strobe.regwrite = 1'b1;
                exp_mux.memtoreg    = 1'b1;
                mux_mask.regdst     = 1'b1;
                mux_mask.memtoreg   = 1'b1;
            end
            StAluWb: begin
                exp_strobe.regwrite = 1'b1;
                exp_mux.regdst      = 1'b1;
                mux_mask.regdst     = 1'b1;
                mux_mask.memtoreg   = 1'b1;
            end
            StAddiWb: begin
                exp_strobe.regwrite = 1'b1;
                mux_mask.regdst     = 1'b1;
                mux_mask.memtoreg   = 1'b1;
            end
            StExecute: begin
                alu_check = 1'b1;
                case (funct)
                    FUNCT_ADD: exp_alu = ALU_ADD;
                    FUNCT_SUB: exp_alu = ALU_SUB;
                    FUNCT_AND: exp_alu = ALU_AND;
                    FUNCT_OR:  exp_alu = ALU_OR;
                    FUNCT_SLT: exp_alu = ALU_SLT;
                    default:   funct_bad = 1'b1;
                endcase
            end
            StBranch: begin
                exp_strobe.pcen  = zero;
                exp_mux.alusrca  = 1'b1;
                exp_mux.pcsrc    = 2'b01;
                mux_mask.alusrca = 1'b1;
                mux_mask.alusrcb = 2'b11;
                mux_mask.pcsrc   = 2'b11;
                exp_alu          = ALU_SUB;
                alu_check        = 1'b1;
            end
            StJump: begin
                exp_strobe.pcen = 1'b1;
                exp_mux.pcsrc   = 2'b10;
                mux_mask.pcsrc  = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_monitor.sv
// Passive checker for a multicycle MIPS controller. Runs its own copy of the
// controller FSM and compares the observed controller outputs against the
// expected values for each state, flagging the highest-priority mismatch.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   op, funct, zero       instruction fields and ALU zero flag
//   pcen .. regdst        observed single-bit controller outputs
//   alusrcb, pcsrc        observed 2-bit mux selects
//   alucontrol            observed ALU control
//   retire, retire_cls    pulse and class on the last cycle of an instruction
//   instr_count           saturating retired-instruction count
//   err                   registered one-cycle error pulse
//   err_sticky, err_code, err_state  first error, held until reset
module mips_ctrl_monitor
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             pcen,
    input  logic             memwrite,
    input  logic             irwrite,
    input  logic             regwrite,
    input  logic             alusrca,
    input  logic             iord,
    input  logic             memtoreg,
    input  logic             regdst,
    input  logic [1:0]       alusrcb,
    input  logic [1:0]       pcsrc,
    input  logic [3:0]       alucontrol,
    output logic             retire,
    output logic [2:0]       retire_cls,
    output logic [CNT_W-1:0] instr_count,
    output logic             err,
    output logic             err_sticky,
    output logic [2:0]       err_code,
    output logic [3:0]       err_state
);

    localparam logic [CNT_W-1:0] CntOne = 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             err_q, sticky_q;
    err_e             code_q, code_now;
    state_e           estate_q;

    strobe_t    obs_strobe, exp_strobe;
    mux_t       obs_mux, exp_mux, mux_mask;
    logic [3:0] exp_alu;
    logic       alu_check, funct_bad;
    logic       bad_op, strobe_bad, mux_bad, alu_bad;
    logic       retire_now;
    cls_e       cls_now;

    assign obs_strobe = {pcen, memwrite, irwrite, regwrite};
    assign obs_mux    = {iord, alusrca, memtoreg, regdst, alusrcb, pcsrc};

    mips_ctrl_expect u_expect (
        .state      (state_q),
        .funct      (funct),
        .zero       (zero),
        .exp_strobe (exp_strobe),
        .exp_mux    (exp_mux),
        .mux_mask   (mux_mask),
        .exp_alu    (exp_alu),
        .alu_check  (alu_check),
        .funct_bad  (funct_bad)
    );

    // Expected-sequence next state; op is only looked at in DECODE and MEMADR
    always_comb begin
        state_d = StFetch;
        bad_op  = 1'b0;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExecute;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default:      bad_op  = 1'b1;
                endcase
            end
            StMemAdr:  state_d = (op == OP_LW) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StExecute: state_d = StAluWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    // Case-inequality so that X/Z on a checked bit counts as a mismatch;
    // masked-off bits are forced to 0 on both sides and never compare.
    always_comb begin
        strobe_bad = (obs_strobe !== exp_strobe);
        mux_bad    = ((obs_mux & mux_mask) !== (exp_mux & mux_mask));
        alu_bad    = alu_check && (funct_bad || (alucontrol !== exp_alu));

        code_now = ErrNone;
        if (bad_op) begin
            code_now = ErrBadop;
        end else if (strobe_bad) begin
            code_now = ErrStrobe;
        end else if (alu_bad) begin
            code_now = ErrAlu;
        end else if (mux_bad) begin
            code_now = ErrMux;
        end
    end

    assign cls_now    = retire_class(state_q);
    assign retire_now = (cls_now != ClsNone);

    // Gated by reset so a state left over from before reset never retires
    assign retire     = reset & retire_now;
    assign retire_cls = reset ? cls_now : ClsNone;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StFetch;
            count_q  <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            code_q   <= ErrNone;
            estate_q <= StFetch;
        end else begin
            state_q <= state_d;
            if (retire_now && (count_q != '1)) begin
                count_q <= count_q + CntOne;
            end
            err_q <= (code_now != ErrNone);
            if (!sticky_q && (code_now != ErrNone)) begin
                sticky_q <= 1'b1;
                code_q   <= code_now;
                estate_q <= state_q;
            end
        end
    end

    assign instr_count = count_q;
    assign err         = err_q;
    assign err_sticky  = sticky_q;
    assign err_code    = code_q;
    assign err_state   = estate_q;

endmodule

// File: tb/tb_mips_ctrl_monitor.sv
// Directed self-checking bench for mips_ctrl_monitor. A behavioural "good"
// controller drives the observed signals for a given state; individual
// signals are then corrupted to provoke each error class.
module tb_mips_ctrl_monitor;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol;

    logic        retire, err, err_sticky;
    logic [2:0]  retire_cls, err_code;
    logic [15:0] instr_count;
    logic [3:0]  err_state;

    logic       d4_retire, d4_err, d4_err_sticky;
    logic [2:0] d4_retire_cls, d4_err_code;
    logic [3:0] d4_instr_count, d4_err_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_ctrl_monitor #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .retire(retire), .retire_cls(retire_cls), .instr_count(instr_count),
        .err(err), .err_sticky(err_sticky), .err_code(err_code), .err_state(err_state)
    );

    mips_ctrl_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .retire(d4_retire), .retire_cls(d4_retire_cls), .instr_count(d4_instr_count),
        .err(d4_err), .err_sticky(d4_err_sticky), .err_code(d4_err_code),
        .err_state(d4_err_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Correct controller outputs for state s
    task automatic drive(input state_e s);
        pcen = 0; memwrite = 0; irwrite = 0; regwrite = 0;
        alusrca = 0; iord = 0; memtoreg = 0; regdst = 0;
        alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = 4'b0010;
        case (s)
            StFetch: begin pcen = 1; irwrite = 1; alusrcb = 2'b01; end
            StDecode: alusrcb = 2'b11;
            StMemAdr, StAddiEx: begin alusrca = 1; alusrcb = 2'b10; end
            StMemRd: iord = 1;
            StMemWb: begin regwrite = 1; memtoreg = 1; end
            StMemWr: begin memwrite = 1; iord = 1; end
            StExecute: begin
                alusrca = 1;
                case (funct)
                    6'b100010: alucontrol = 4'b0110;
                    6'b100100: alucontrol = 4'b0000;
                    6'b100101: alucontrol = 4'b0001;
                    6'b101010: alucontrol = 4'b0111;
                    default:   alucontrol = 4'b0010;
                endcase
            end
            StAluWb: begin regwrite = 1; regdst = 1; end
            StAddiWb: regwrite = 1;
            StBranch: begin alusrca = 1; pcsrc = 2'b01; alucontrol = 4'b0110; pcen = zero; end
            StJump: begin pcen = 1; pcsrc = 2'b10; end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input state_e s);
        drive(s);
        tick();
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        reset = 1;
    endtask

    initial begin
        reset = 0; op = OP_LW; funct = FUNCT_ADD; zero = 0;
        drive(StFetch);
        tick();
        tick();
        chk("rst_retire", retire, 0);
        chk("rst_cls", retire_cls, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_err", err, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_code", err_code, 0);
        chk("rst_estate", err_state, 0);

        // LW, clean
        reset = 1;
        cyc(StFetch); cyc(StDecode); cyc(StMemAdr);
        chk("lw_no_early_retire", retire, 0);
        cyc(StMemRd);
        chk("lw_retire", retire, 1);
        chk("lw_cls", retire_cls, 1);
        chk("lw_err", err, 0);
        cyc(StMemWb);
        chk("lw_count", instr_count, 1);
        chk("lw_retire_drop", retire, 0);

        // BEQ taken, then not taken
        op = OP_BEQ; zero = 1;
        cyc(StFetch); cyc(StDecode);
        chk("beq1_retire", retire, 1);
        chk("beq1_cls", retire_cls, 4);
        cyc(StBranch);
        chk("beq1_err", err, 0);
        zero = 0;
        cyc(StFetch); cyc(StDecode); cyc(StBranch);
        chk("beq0_err", err, 0);
        chk("beq_count", instr_count, 3);

        // SW, ADDI, J, RTYPE ADD, all clean
        op = OP_SW;
        cyc(StFetch); cyc(StDecode); cyc(StMemAdr);
        chk("sw_cls", retire_cls, 2);
        cyc(StMemWr);
        op = OP_ADDI;
        cyc(StFetch); cyc(StDecode); cyc(StAddiEx);
        chk("addi_cls", retire_cls, 5);
        cyc(StAddiWb);
        op = OP_J;
        cyc(StFetch); cyc(StDecode);
        chk("j_cls", retire_cls, 6);
        cyc(StJump);
        op = OP_RTYPE; funct = FUNCT_ADD;
        cyc(StFetch); cyc(StDecode); cyc(StExecute);
        chk("add_cls", retire_cls, 3);
        cyc(StAluWb);
        chk("clean_count", instr_count, 7);
        chk("clean_sticky", err_sticky, 0);

        // STROBE: memwrite forced high in FETCH
        drive(StFetch); memwrite = 1; tick();
        chk("strobe_err", err, 1);
        chk("strobe_code", err_code, 2);
        chk("strobe_estate", err_state, 0);
        chk("strobe_sticky", err_sticky, 1);
        cyc(StDecode);
        chk("strobe_pulse_end", err, 0);
        cyc(StExecute); cyc(StAluWb);
        chk("strobe_code_held", err_code, 2);
        chk("strobe_count", instr_count, 8);

        // ALU: SLT with ADD alucontrol
        do_reset();
        funct = FUNCT_SLT;
        cyc(StFetch); cyc(StDecode);
        drive(StExecute); alucontrol = 4'b0010; tick();
        chk("alu_err", err, 1);
        chk("alu_code", err_code, 3);
        chk("alu_estate", err_state, 6);
        chk("alu_retire", retire, 1);
        chk("alu_cls", retire_cls, 3);
        cyc(StAluWb);
        chk("alu_count", instr_count, 1);

        // BADOP in DECODE
        do_reset();
        op = 6'b111111;
        cyc(StFetch); cyc(StDecode);
        chk("badop_err", err, 1);
        chk("badop_code", err_code, 1);
        chk("badop_estate", err_state, 1);
        chk("badop_no_retire", retire, 0);
        op = OP_J;
        cyc(StFetch);
        chk("badop_next_fetch", err, 0);
        cyc(StDecode);
        chk("badop_then_j", retire_cls, 6);
        cyc(StJump);
        chk("badop_count", instr_count, 1);

        // STROBE outranks ALU and MUX in the same cycle
        do_reset();
        drive(StFetch); memwrite = 1; iord = 1; alucontrol = 4'b0110; tick();
        chk("prio_code", err_code, 2);

        // MUX: iord low in MEMRD; monitor keeps its own sequence
        do_reset();
        op = OP_LW;
        cyc(StFetch); cyc(StDecode); cyc(StMemAdr);
        drive(StMemRd); iord = 0; tick();
        chk("mux_err", err, 1);
        chk("mux_code", err_code, 4);
        chk("mux_estate", err_state, 3);
        chk("mux_retire", retire_cls, 1);
        cyc(StMemWb);

        // Reset in MEMRD of an LW
        cyc(StFetch); cyc(StDecode); cyc(StMemAdr);
        reset = 0;
        drive(StMemRd);
        #1;
        chk("abort_retire_in_rst", retire, 0);
        tick();
        chk("abort_retire", retire, 0);
        chk("abort_count", instr_count, 0);
        chk("abort_err", err, 0);
        chk("abort_sticky", err_sticky, 0);
        chk("abort_code", err_code, 0);
        chk("abort_estate", err_state, 0);
        reset = 1;
        cyc(StFetch);
        chk("abort_fetch_ok", err, 0);
        chk("abort_no_retire", retire, 0);
        cyc(StDecode); cyc(StMemAdr); cyc(StMemRd);
        chk("abort_restart_retire", retire, 1);
        cyc(StMemWb);
        chk("abort_restart_sticky", err_sticky, 0);

        // Saturation with a 4-bit counter
        do_reset();
        op = OP_J;
        for (int i = 1; i <= 20; i++) begin
            cyc(StFetch); cyc(StDecode); cyc(StJump);
            if (i == 14) chk("sat_14", d4_instr_count, 14);
            if (i == 15) chk("sat_15", d4_instr_count, 15);
        end
        chk("sat_20", d4_instr_count, 15);
        chk("wide_20", instr_count, 20);
        chk("sat_clean", err_sticky, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
